// File: rtl/wb_debug_bridge_pkg.sv
// Shared command/status codes and FSM state type for the debug bridge.
// Imported by wb_debug_bridge and dbg_timeout_ctr.
package wb_debug_bridge_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [7:0] ST_OK  = 8'hA5;
  localparam logic [7:0] ST_ERR = 8'hEE;
  localparam logic [7:0] ST_NAK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS,
    RESP_STAT,
    RESP_DATA
  } state_t;

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Load-and-count-down timer: clear reloads LIMIT-1, expired when it hits 0.
// Ports: clk, rst (sync, active-high), clear, expired.
module dbg_timeout_ctr
  import wb_debug_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Loaded at the edge that enters the timed window; the LIMIT-th edge
  // inside the window samples cnt == 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/wb_debug_bridge.sv
// Byte-stream to Wishbone classic master bridge for host debug access.
// Ports: clk, rst, rx_* (byte in), tx_* (byte out), wb_* master, busy.
// Optional WB_DEBUG_BRIDGE_FRAME_TIMEOUT_EN: drop stalled partial frames.
module wb_debug_bridge
  import wb_debug_bridge_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT   = 1024,
  parameter int unsigned FRAME_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        busy
);

  if (BUS_TIMEOUT < 1 || FRAME_TIMEOUT < 1) begin : g_bad_param
    $error("wb_debug_bridge: timeouts must be >= 1");
  end

  state_t      state;
  logic [1:0]  idx;
  logic        is_rd;
  logic [31:0] rdata;
  logic        rx_fire;
  logic        bus_expired;
  logic        frame_expired;

  assign rx_ready = ~rst & ((state == IDLE) ||
                            (state == ADDR) ||
                            (state == WDATA));
  assign rx_fire  = rx_valid & rx_ready;
  assign busy     = (state != IDLE);
  assign wb_stb   = wb_cyc;
  assign wb_sel   = 4'hF;

  dbg_timeout_ctr #(
    .LIMIT (BUS_TIMEOUT)
  ) u_bus_to (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != BUS),
    .expired (bus_expired)
  );

`ifdef WB_DEBUG_BRIDGE_FRAME_TIMEOUT_EN
  logic frame_clr;

  // Restart on every accepted byte and whenever no frame is open.
  assign frame_clr = rx_fire |
                     ~((state == ADDR) || (state == WDATA));

  dbg_timeout_ctr #(
    .LIMIT (FRAME_TIMEOUT)
  ) u_frame_to (
    .clk     (clk),
    .rst     (rst),
    .clear   (frame_clr),
    .expired (frame_expired)
  );
`else
  assign frame_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      is_rd    <= 1'b0;
      rdata    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      wb_cyc   <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_dat_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            idx <= '0;
            if (rx_data == CMD_READ ||
                rx_data == CMD_WRITE) begin
              is_rd <= (rx_data == CMD_READ);
              state <= ADDR;
            end else begin
              is_rd    <= 1'b0;
              tx_data  <= ST_NAK;
              tx_valid <= 1'b1;
              state    <= RESP_STAT;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            wb_addr <= {wb_addr[23:0], rx_data};
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (is_rd) begin
                wb_cyc <= 1'b1;
                wb_we  <= 1'b0;
                state  <= BUS;
              end else begin
                state <= WDATA;
              end
            end
          end else if (frame_expired) begin
            state <= IDLE;
          end
        end
        WDATA: begin
          if (rx_fire) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_data};
            idx      <= idx + 2'd1;
            if (idx == 2'd3) begin
              wb_cyc <= 1'b1;
              wb_we  <= 1'b1;
              state  <= BUS;
            end
          end else if (frame_expired) begin
            state <= IDLE;
          end
        end
        BUS: begin
          // ack outranks err, err outranks timeout.
          if (wb_ack) begin
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            rdata    <= is_rd ? wb_dat_i : 32'h0;
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= RESP_STAT;
          end else if (wb_err || bus_expired) begin
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            rdata    <= 32'h0;
            tx_data  <= ST_ERR;
            tx_valid <= 1'b1;
            state    <= RESP_STAT;
          end
        end
        RESP_STAT: begin
          if (tx_ready) begin
            if (is_rd) begin
              tx_data <= rdata[31:24];
              rdata   <= {rdata[23:0], 8'h00};
              idx     <= '0;
              state   <= RESP_DATA;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        RESP_DATA: begin
          if (tx_ready) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data <= rdata[31:24];
              rdata   <= {rdata[23:0], 8'h00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_debug_bridge.md
# wb_debug_bridge

Byte-stream to Wishbone master bridge giving a host PC direct register and memory access to the inverter SoC over the debug serial link. It takes command frames from a UART receiver's byte stream, issues single Wishbone classic read/write cycles as a second bus initiator alongside the CPU data bus, and returns status and read data to the UART transmitter. It is the host-facing end of the SoC bus: it reaches peripherals such as PWM, ADC and protection without firmware involvement.

## Interface
- BUS_TIMEOUT, 1024: maximum cycles a bus cycle may wait for ack/err.
- FRAME_TIMEOUT, 50000: maximum idle cycles between bytes of one frame. This is 1 ms at 50 MHz, and applies only with the macro below.
- clk  in  1  system clock, 50 MHz; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts a byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts a byte.
- wb_addr  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_we  out  1  write enable.
- wb_sel  out  4  byte select; always 4'hF.
- wb_cyc, wb_stb  out  1 each  cycle and strobe; always driven identically.
- wb_ack, wb_err  in  1 each  slave terminate.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame format, all multi-byte fields big-endian:
  - Read: CMD 0x01, then ADDR[4].
  - Write: CMD 0x02, then ADDR[4], then DATA[4].
- Responses:
  - Status byte: 0xA5 = OK, 0xEE = bus error or timeout, 0x3F = unknown command.
  - A read response is the status byte plus 4 data bytes, MSB first. The data bytes are 0x00 when status is not 0xA5.
  - A write response is the status byte only.
- State machine:
  - IDLE -> ADDR on CMD 0x01 or 0x02.
  - IDLE -> RESP_STAT with 0x3F on any other CMD byte.
  - ADDR: shift 4 bytes into the address register. Then go to WDATA for a write, or to BUS for a read.
  - WDATA: shift 4 bytes into the write-data register, then go to BUS.
  - BUS: hold wb_cyc/wb_stb/wb_we/wb_addr/wb_dat_o until termination, then go to RESP_STAT.
  - RESP_STAT: present the status byte. On handshake, go to RESP_DATA for a read, or to IDLE otherwise.
  - RESP_DATA: present 4 bytes, then go to IDLE.
- rx_ready = 1 only in IDLE, ADDR and WDATA. A byte is consumed on rx_valid & rx_ready.
- tx_valid = 1 only in RESP_STAT and RESP_DATA. tx_data stays stable until tx_ready is seen. A byte is consumed on tx_valid & tx_ready.
- Bus termination:
  - Termination is evaluated in this priority order: ack, then err, then timeout.
  - ack with a read: capture wb_dat_i, status 0xA5.
  - err: status 0xEE.
  - Timeout: status 0xEE.
  - A timeout is declared after BUS_TIMEOUT cycles of BUS without ack or err. If ack arrives in the cycle the timeout fires, ack wins.
- Reset in any state returns to IDLE and drives all outputs to their reset values on the next edge, aborting any open bus cycle.
- Only one transaction is outstanding at a time. Bytes are not accepted during BUS or the response states.

## Timing
- Output reset values:
  - rx_ready = 0 in the reset cycle and 1 from the first cycle after rst deasserts.
  - tx_valid = 0, tx_data = 0.
  - wb_cyc = wb_stb = wb_we = 0, wb_addr = 0, wb_dat_o = 0, wb_sel = 4'hF.
  - busy = 0.
- Frame input to bus:
  - wb_cyc/wb_stb rise on the clock edge after the last frame byte is accepted.
  - On the edge where ack or err is sampled high, wb_cyc/wb_stb fall and read data is registered in the same edge.
  - A zero-wait-state slave therefore gives 1 bus cycle.
- Response output: tx_valid rises on the edge that ends BUS, i.e. the cycle after ack.
- Timeout counter: an $clog2-width counter that clears on entry to BUS.
- Back-to-back frames: the next CMD can be accepted the cycle after the final response byte handshakes.

## Configuration
- WB_DEBUG_BRIDGE_FRAME_TIMEOUT_EN defined:
  - In ADDR or WDATA, FRAME_TIMEOUT consecutive cycles without an accepted byte discards the partial frame and returns to IDLE.
  - No response is sent and no bus cycle is issued.
  - This resynchronises after a host crash or dropped byte.
- Macro undefined:
  - A partial frame waits indefinitely.
  - The FRAME_TIMEOUT parameter is ignored and the counter logic is absent.

## Structure
- Shared package wb_debug_bridge_pkg holds:
  - Command codes: CMD_READ = 8'h01, CMD_WRITE = 8'h02.
  - Status codes: ST_OK = 8'hA5, ST_ERR = 8'hEE, ST_NAK = 8'h3F.
  - State enum: IDLE, ADDR, WDATA, BUS, RESP_STAT, RESP_DATA.
- One sub-module, dbg_timeout_ctr:
  - Parameterised load-and-count-down timer with a clear input and an expired output.
  - Instanced once for the bus timeout.
  - Instanced a second time for the frame timeout, only under the macro.

## Test plan
- Write: bytes 02 00 02 00 10 12 34 56 78 with ack after 2 wait cycles -> wb_addr = 0x00020010, wb_dat_o = 0x12345678, wb_we = 1, wb_sel = F; tx sequence A5.
- Read: bytes 01 00 02 00 10 with ack on the first cycle and wb_dat_i = 0xDEADBEEF -> wb_we = 0; tx sequence A5 DE AD BE EF; cyc high exactly 1 cycle.
- Read of an unmapped address, slave never acks, BUS_TIMEOUT = 16 -> cyc drops after 16 cycles; tx sequence EE 00 00 00 00; the next frame works.
- Errors and tx back-pressure:
  - CMD 0x55 -> tx 3F only, no bus cycle.
  - wb_err on a write -> tx EE.
  - tx_ready held low 10 cycles -> tx_data stable throughout.
- Reset mid-BUS with cyc high -> next cycle cyc = 0, tx_valid = 0, busy = 0, rx_ready = 1.
- With WB_DEBUG_BRIDGE_FRAME_TIMEOUT_EN and FRAME_TIMEOUT = 100: send 01 00, stall 100 cycles -> returns to IDLE with no tx. A following full read frame then completes normally.
